// File: rtl/rs_pkg.sv
// Shared constants, state encoding and GF(2^3) helpers for the RS encoder.
// Field generated by x^3+x+1; generator g(x)=x^2+6x+3.
package rs_pkg;

  localparam int RS_W = 3;
  localparam int RS_N = 7;
  localparam int RS_K = RS_N - 2;

  localparam logic [RS_W:0] PRIM_POLY = 4'b1011;

  typedef logic [RS_W-1:0] sym_t;

  localparam sym_t G1 = 3'd6;
  localparam sym_t G0 = 3'd3;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t ENCODE = 2'd1;
  localparam state_t DONE   = 2'd2;

  // Shift-and-add multiply; constant operands fold into XOR networks.
  function automatic sym_t gfmul(sym_t a, sym_t b);
    sym_t p;
    sym_t x;
    p = '0;
    x = a;
    for (int i = 0; i < RS_W; i++) begin
      if (b[i])
        p = p ^ x;
      if (x[RS_W-1])
        x = (x << 1) ^ PRIM_POLY[RS_W-1:0];
      else
        x = x << 1;
    end
    return p;
  endfunction

endpackage

// File: rtl/rs_parity_lfsr.sv
// Two-register parity LFSR dividing by g(x)=x^2+G1*x+G0.
// Exposes the next-state values so the top can capture final parity.
module rs_parity_lfsr
  import rs_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic step,
  input  sym_t symbol,
  output sym_t r1,
  output sym_t r0,
  output sym_t nxt_r1,
  output sym_t nxt_r0
);

  sym_t fb;

  assign fb     = symbol ^ r1;
  assign nxt_r1 = r0 ^ gfmul(fb, G1);
  assign nxt_r0 = gfmul(fb, G0);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r1 <= '0;
      r0 <= '0;
    end else if (step) begin
      r1 <= nxt_r1;
      r0 <= nxt_r0;
    end
  end

endmodule

// File: rtl/rs_encoder.sv
// Systematic RS(7,5) encoder over GF(2^3), one message symbol per clock.
// Optional RS_ENC_ERR_INJECT_EN adds a single-symbol error injector.
module rs_encoder
  import rs_pkg::*;
#(
  parameter int SYMBOL_WIDTH = RS_W,
  parameter int N            = RS_N
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [(N-2)*SYMBOL_WIDTH-1:0]  message,
`ifdef RS_ENC_ERR_INJECT_EN
  input  logic                           inj_en,
  input  logic [$clog2(N)-1:0]           inj_pos,
  input  logic [SYMBOL_WIDTH-1:0]        inj_val,
`endif
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N*SYMBOL_WIDTH-1:0]      codeword
);

  localparam int K  = N - 2;
  localparam int CW = $clog2(K);

  state_t                       state;
  logic [CW-1:0]                count;
  logic [K*SYMBOL_WIDTH-1:0]    msg_reg;
  logic [N*SYMBOL_WIDTH-1:0]    inj_mask;
  sym_t                         cur_sym;
  sym_t                         r1;
  sym_t                         r0;
  sym_t                         nxt_r1;
  sym_t                         nxt_r0;
  logic                         accept;

  assign in_ready = (state == IDLE) && !reset;
  assign accept   = in_valid && in_ready;
  assign cur_sym  = msg_reg[count*SYMBOL_WIDTH +: SYMBOL_WIDTH];

`ifdef RS_ENC_ERR_INJECT_EN
  always_comb begin
    inj_mask = '0;
    if (inj_en && (32'(inj_pos) < N))
      inj_mask[inj_pos*SYMBOL_WIDTH +: SYMBOL_WIDTH] = inj_val;
  end
`else
  assign inj_mask = '0;
`endif

  rs_parity_lfsr u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .step   (state == ENCODE),
    .symbol (cur_sym),
    .r1     (r1),
    .r0     (r0),
    .nxt_r1 (nxt_r1),
    .nxt_r0 (nxt_r0)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      msg_reg   <= '0;
      out_valid <= 1'b0;
      codeword  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            msg_reg <= message;
            count   <= CW'(K-1);
            state   <= ENCODE;
          end
        end
        ENCODE: begin
          if (count == '0) begin
            codeword  <= {msg_reg, nxt_r1, nxt_r0} ^ inj_mask;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            count <= count - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_encoder.sv
// Scoreboard bench for rs_encoder: table-based GF model, syndromes, stalls.
// Define RS_ENC_ERR_INJECT_EN to also exercise the injector ports.
module tb_rs_encoder;

  logic        clk = 0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] message;
  logic        out_valid;
  logic        out_ready;
  logic [20:0] codeword;
`ifdef RS_ENC_ERR_INJECT_EN
  logic        inj_en;
  logic [2:0]  inj_pos;
  logic [2:0]  inj_val;
`endif

  int checks = 0;
  int errors = 0;
  logic [20:0] exp_q[$];
  int exp_t[7] = '{1, 2, 4, 3, 6, 7, 5};

  always #5 clk = ~clk;

  rs_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .message   (message),
`ifdef RS_ENC_ERR_INJECT_EN
    .inj_en    (inj_en),
    .inj_pos   (inj_pos),
    .inj_val   (inj_val),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .codeword  (codeword)
  );

  function automatic logic [2:0] fmul(logic [2:0] a, logic [2:0] b);
    int la = 0;
    int lb = 0;
    if (a == 0 || b == 0) return 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (exp_t[i] == int'(a)) la = i;
      if (exp_t[i] == int'(b)) lb = i;
    end
    return 3'(exp_t[(la + lb) % 7]);
  endfunction

  // Long division of m(x)*x^2 by g(x); remainder is the parity.
  function automatic logic [20:0] model(logic [14:0] m);
    logic [2:0] c[7];
    logic [2:0] q;
    for (int i = 0; i < 7; i++) c[i] = 3'd0;
    for (int i = 0; i < 5; i++) c[i+2] = m[i*3 +: 3];
    for (int d = 6; d >= 2; d--) begin
      q      = c[d];
      c[d-1] = c[d-1] ^ fmul(q, 3'd6);
      c[d-2] = c[d-2] ^ fmul(q, 3'd3);
      c[d]   = 3'd0;
    end
    return {m, c[1], c[0]};
  endfunction

  function automatic logic [2:0] synd(logic [20:0] cw, logic [2:0] a);
    logic [2:0] s = 3'd0;
    for (int i = 6; i >= 0; i--) s = fmul(s, a) ^ cw[i*3 +: 3];
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [14:0] m, input logic [20:0] mask);
    int n = 0;
    message  = m;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("send_timeout", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    message  = 15'($urandom);
    exp_q.push_back(model(m) ^ mask);
  endtask

  task automatic recv(output logic [20:0] got);
    int n = 0;
    logic [20:0] e;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", 32'(n), 32'd5);
    e   = (exp_q.size() > 0) ? exp_q.pop_front() : 21'h1fffff;
    got = codeword;
    chk("codeword", 32'(codeword), 32'(e));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("ov_drop", 32'(out_valid), 32'd0);
    chk("ir_back", 32'(in_ready), 32'd1);
  endtask

  logic [20:0] cw_a;
  logic [20:0] cw_b;
  logic [20:0] held;
  logic [14:0] rm;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    message   = '0;
`ifdef RS_ENC_ERR_INJECT_EN
    inj_en  = 1'b0;
    inj_pos = 3'd0;
    inj_val = 3'd0;
`endif
    @(posedge clk); #1;
    chk("ir_in_reset", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_cw", 32'(codeword), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_ir", 32'(in_ready), 32'd1);

    // out_ready while idle is ignored
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("ordy_idle", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    send(15'h0, 21'h0);
    recv(cw_a);
    chk("zero_cw", 32'(cw_a), 32'h0);

    send(15'b001_000_000_000_000, 21'h0);
    recv(cw_a);
    chk("m4_cw", 32'(cw_a), 32'(21'b001_000_000_000_000_110_010));

    send(15'b000_000_000_000_001, 21'h0);
    recv(cw_b);
    chk("m0_cw", 32'(cw_b), 32'(21'b000_000_000_000_001_110_011));
    chk("linear", 32'(cw_a[5:0] ^ cw_b[5:0]), 32'(6'b000_001));

    // Stall: codeword held, new input refused
    rm = 15'h5a3c;
    send(rm, 21'h0);
    repeat (5) @(posedge clk);
    #1;
    chk("stall_ov", 32'(out_valid), 32'd1);
    held     = codeword;
    in_valid = 1'b1;
    message  = 15'h1234;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 9) begin
        chk("stall_cw", 32'(codeword), 32'(held));
        chk("stall_ir", 32'(in_ready), 32'd0);
        chk("stall_ov2", 32'(out_valid), 32'd1);
      end
    end
    in_valid = 1'b0;
    chk("stall_model", 32'(codeword), 32'(exp_q.pop_front()));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("rel_ir", 32'(in_ready), 32'd1);
    chk("rel_ov", 32'(out_valid), 32'd0);

    // Reset in the third ENCODE cycle discards the message
    send(15'h7fff, 21'h0);
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ov", 32'(out_valid), 32'd0);
    reset = 1'b0;
    #1;
    chk("mid_rst_ir", 32'(in_ready), 32'd1);
    repeat (8) @(posedge clk);
    #1;
    chk("mid_rst_quiet", 32'(out_valid), 32'd0);
    send(15'b001_000_000_000_000, 21'h0);
    recv(cw_a);
    chk("post_rst_par", 32'(cw_a[5:0]), 32'(6'b110_010));

    for (int t = 0; t < 6; t++) begin
      send(15'($urandom), 21'h0);
      recv(cw_a);
      chk("s1", 32'(synd(cw_a, 3'd2)), 32'd0);
      chk("s2", 32'(synd(cw_a, 3'd4)), 32'd0);
    end

`ifdef RS_ENC_ERR_INJECT_EN
    inj_en  = 1'b1;
    inj_pos = 3'd3;
    inj_val = 3'd5;
    send(15'b001_000_000_000_000, 21'h000a00);
    recv(cw_a);
    chk("inj_cw", 32'(cw_a), 32'(21'b001_000_000_101_000_110_010));
    chk("inj_s1", 32'(synd(cw_a, 3'd2) != 3'd0), 32'd1);
    inj_pos = 3'd7;
    send(15'b001_000_000_000_000, 21'h0);
    recv(cw_a);
    chk("inj_oob", 32'(cw_a), 32'(21'b001_000_000_000_000_110_010));
    inj_en = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
